// File: rtl/pc_gen_pkg.sv
// rtl/pc_gen_pkg.sv - shared CPU constants and fetch-redirect FSM state type
package pc_gen_pkg;

  // Fetch FSM: RUN fetches normally, PEND holds a redirect captured under stall
  typedef enum logic {
    RUN  = 1'b0,
    PEND = 1'b1
  } pc_state_e;

  localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_0000;
  localparam int unsigned PC_STEP_DEFAULT  = 4;

  // J-format target: upper nibble of the delay-slot PC, word index, byte aligned
  function automatic logic [31:0] jump_target(input logic [31:0] base,
                                              input logic [25:0] idx);
    return {base[31:28], idx, 2'b00};
  endfunction

endpackage

// File: rtl/pc_gen_adder32_cla.sv
// rtl/pc_gen_adder32_cla.sv - 32-bit adder built from chained 4-bit carry-lookahead slices
module adder32_cla (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] sum_o
);

  // Sum bits of one slice; only the lower three generate terms feed internal carries
  function automatic logic [3:0] cla4_sum(input logic [3:0] a,
                                          input logic [3:0] b,
                                          input logic       cin);
    logic [2:0] g;
    logic [3:0] p;
    logic [3:0] c;
    g    = a[2:0] & b[2:0];
    p    = a ^ b;
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    return p ^ c;
  endfunction

  // Lookahead carry out of one slice into the next
  function automatic logic cla4_cout(input logic [3:0] a,
                                     input logic [3:0] b,
                                     input logic       cin);
    logic [3:0] g;
    logic [3:0] p;
    g = a & b;
    p = a ^ b;
    return g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) |
           (p[3] & p[2] & p[1] & g[0]) | (&p & cin);
  endfunction

  logic [7:0] c;

  assign c[0] = 1'b0;

  // Eight slices; the final carry out is dropped so the sum wraps modulo 2^32
  for (genvar s = 0; s < 8; s++) begin : g_slice
    assign sum_o[4*s +: 4] = cla4_sum(a_i[4*s +: 4], b_i[4*s +: 4], c[s]);
    if (s < 7) begin : g_carry
      assign c[s+1] = cla4_cout(a_i[4*s +: 4], b_i[4*s +: 4], c[s]);
    end
  end

endmodule

// File: rtl/pc_gen.sv
// rtl/pc_gen.sv - program counter with prioritised redirects, stall-pending capture and flush
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter logic [31:0] RESET_PC = PC_RESET_DEFAULT,
  parameter int unsigned PC_STEP  = PC_STEP_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [31:0] br_base,
  input  logic [31:0] br_offset,
  input  logic        jump,
  input  logic [25:0] jump_index,
  input  logic        jr,
  input  logic [31:0] jr_target,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        fetch_valid,
  output logic        flush
);

  localparam logic [31:0] STEP = 32'(PC_STEP);

  pc_state_e   state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pend_q, pend_d;
  logic        live_q;

  logic [31:0] br_tgt;
  logic [31:0] redir_tgt;
  logic        redirect;

  adder32_cla u_add_seq (
    .a_i   (pc_q),
    .b_i   (STEP),
    .sum_o (pc_plus4)
  );

  adder32_cla u_add_br (
    .a_i   (br_base),
    .b_i   (br_offset << 2),
    .sum_o (br_tgt)
  );

  assign redirect = jr | jump | br_taken;

  // Redirect target selection: jr beats jump beats branch
  always_comb begin
    redir_tgt = br_tgt;
    if (jr) begin
      redir_tgt = jr_target;
    end else if (jump) begin
      redir_tgt = jump_target(br_base, jump_index);
    end
  end

  // Flush fires the cycle a redirect is actually applied; nothing is live until
  // the first edge after reset
  assign flush       = live_q & ~stall & ((state_q == PEND) | redirect);
  assign fetch_valid = live_q & (state_q == RUN) & ~flush;
  assign pc          = pc_q;

  // Next PC, pending target and state
  always_comb begin
    pc_d    = pc_q;
    pend_d  = pend_q;
    state_d = state_q;
    if (live_q) begin
      case (state_q)
        RUN: begin
          if (redirect) begin
            if (stall) begin
              pend_d  = redir_tgt;
              state_d = PEND;
            end else begin
              pc_d = redir_tgt;
            end
          end else if (!stall) begin
            pc_d = pc_plus4;
          end
        end
        PEND: begin
          if (stall) begin
            if (redirect) begin
              pend_d = redir_tgt;
            end
          end else begin
            pc_d    = redirect ? redir_tgt : pend_q;
            pend_d  = '0;
            state_d = RUN;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  // State registers; reset drops any pending redirect
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      pend_q  <= '0;
      live_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pend_q  <= pend_d;
      live_q  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pc_gen.sv
// tb/tb_pc_gen.sv - directed self-checking bench for pc_gen
module tb_pc_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        br_taken;
  logic [31:0] br_base;
  logic [31:0] br_offset;
  logic        jump;
  logic [25:0] jump_index;
  logic        jr;
  logic [31:0] jr_target;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        fetch_valid;
  logic        flush;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pc_gen dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .br_taken    (br_taken),
    .br_base     (br_base),
    .br_offset   (br_offset),
    .jump        (jump),
    .jump_index  (jump_index),
    .jr          (jr),
    .jr_target   (jr_target),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .fetch_valid (fetch_valid),
    .flush       (flush)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clr;
    br_taken = 1'b0;
    jump     = 1'b0;
    jr       = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    stall      = 1'b0;
    br_taken   = 1'b0;
    br_base    = '0;
    br_offset  = '0;
    jump       = 1'b0;
    jump_index = '0;
    jr         = 1'b0;
    jr_target  = '0;

    // reset state
    @(negedge clk);
    tick;
    chk("rst_pc", pc, 32'h0);
    chk("rst_pc4", pc_plus4, 32'h4);
    chk("rst_fv", fetch_valid, 0);
    chk("rst_flush", flush, 0);

    // release: first edge goes live at RESET_PC, then sequential advance
    rst = 1'b0;
    #1 chk("pre_live_fv", fetch_valid, 0);
    tick; chk("seq0_pc", pc, 32'h0); chk("seq0_fv", fetch_valid, 1);
    tick; chk("seq1_pc", pc, 32'h4); chk("seq1_fv", fetch_valid, 1);
    tick; chk("seq2_pc", pc, 32'h8);
    tick; chk("seq3_pc", pc, 32'hC); chk("seq3_flush", flush, 0);

    // jr to 0x100
    jr = 1'b1; jr_target = 32'h100;
    #1 chk("jr_flush", flush, 1); chk("jr_fv", fetch_valid, 0);
    tick; clr;
    #1 chk("jr_pc", pc, 32'h100); chk("jr_flush_end", flush, 0); chk("jr_fv_end", fetch_valid, 1);

    // backward branch 0x104 + (-2 << 2) = 0xFC
    br_taken = 1'b1; br_base = 32'h104; br_offset = 32'hFFFF_FFFE;
    #1 chk("br_flush", flush, 1);
    tick; clr;
    #1 chk("br_pc", pc, 32'hFC); chk("br_flush_end", flush, 0);

    // all three at once: jr wins, single flush
    jr = 1'b1; jump = 1'b1; br_taken = 1'b1; jr_target = 32'h400;
    jump_index = 26'h0000123; br_base = 32'h0000_2000; br_offset = 32'h10;
    #1 chk("all_flush", flush, 1);
    tick; clr;
    #1 chk("all_pc", pc, 32'h400); chk("all_flush_end", flush, 0);
    tick; chk("all_next_pc", pc, 32'h404); chk("all_next_flush", flush, 0);

    // jump beats branch: {0xA, 0x100, 00} = 0xA000_0400
    jump = 1'b1; br_taken = 1'b1; br_base = 32'hA000_0000; jump_index = 26'h0000100;
    tick; clr;
    #1 chk("jmp_pc", pc, 32'hA000_0400);

    // stall in RUN holds pc, fetch stays valid
    stall = 1'b1;
    tick;
    chk("stall_pc", pc, 32'hA000_0400); chk("stall_fv", fetch_valid, 1); chk("stall_flush", flush, 0);

    // jump under stall for three cycles -> PEND, released to 0x1000_0040
    jump = 1'b1; jump_index = 26'h0000010; br_base = 32'h1000_0008;
    #1 chk("pend_req_flush", flush, 0);
    tick; jump = 1'b0;
    #1 chk("pend1_pc", pc, 32'hA000_0400); chk("pend1_fv", fetch_valid, 0); chk("pend1_flush", flush, 0);
    tick; chk("pend2_pc", pc, 32'hA000_0400); chk("pend2_fv", fetch_valid, 0);
    tick; chk("pend3_pc", pc, 32'hA000_0400); chk("pend3_fv", fetch_valid, 0);
    stall = 1'b0;
    #1 chk("pend_rel_flush", flush, 1); chk("pend_rel_fv", fetch_valid, 0);
    tick;
    chk("pend_rel_pc", pc, 32'h1000_0040); chk("pend_rel_flush_end", flush, 0);
    chk("pend_rel_fv_end", fetch_valid, 1);

    // redirect while pending overwrites the captured target
    stall = 1'b1; jump = 1'b1;
    tick; clr; jr = 1'b1; jr_target = 32'h800;
    tick; clr; stall = 1'b0;
    #1 chk("ovw_flush", flush, 1);
    tick; chk("ovw_pc", pc, 32'h800);

    // same-cycle redirect on release beats the captured one: 0x2000 + 4
    stall = 1'b1; jr = 1'b1; jr_target = 32'h900;
    tick; clr; stall = 1'b0; br_taken = 1'b1; br_base = 32'h2000; br_offset = 32'h1;
    #1 chk("win_flush", flush, 1);
    tick; clr;
    #1 chk("win_pc", pc, 32'h2004); chk("win_flush_end", flush, 0);

    // wrap at the top of the address space
    jr = 1'b1; jr_target = 32'hFFFF_FFFC;
    tick; clr;
    #1 chk("wrap_pc", pc, 32'hFFFF_FFFC); chk("wrap_pc4", pc_plus4, 32'h0);
    tick; chk("wrap_next_pc", pc, 32'h0);

    // reset mid-PEND drops the pending redirect
    tick; stall = 1'b1; jr = 1'b1; jr_target = 32'h900;
    tick; clr;
    chk("prst_fv", fetch_valid, 0);
    rst = 1'b1;
    #1 chk("prst_pc", pc, 32'h0); chk("prst_fv_rst", fetch_valid, 0); chk("prst_flush", flush, 0);
    tick; rst = 1'b0; stall = 1'b0;
    #1 chk("prst_rel_flush", flush, 0);
    tick; chk("prst_live_pc", pc, 32'h0); chk("prst_live_fv", fetch_valid, 1); chk("prst_live_flush", flush, 0);
    tick; chk("prst_adv_pc", pc, 32'h4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_gen.md
PC_GEN -- requirements
Module: pc_gen

Interface
Parameters:
REQ-001 SHALL provide parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 SHALL provide parameter PC_STEP, default 4, sequential increment in bytes.

Ports:
REQ-003 SHALL have clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have stall  input  1  hold PC (IF/ID stall from hazard unit).
REQ-006 SHALL have br_taken  input  1  branch resolved taken this cycle.
REQ-007 SHALL have br_base  input  32  PC+4 of the branch instruction.
REQ-008 SHALL have br_offset  input  32  sign-extended word offset (immediate).
REQ-009 SHALL have jump  input  1  J/JAL redirect this cycle.
REQ-010 SHALL have jump_index  input  26  J-format instruction index.
REQ-011 SHALL have jr  input  1  JR/JALR redirect this cycle.
REQ-012 SHALL have jr_target  input  32  register-sourced target.
REQ-013 SHALL have pc  output  32  current fetch address.
REQ-014 SHALL have pc_plus4  output  32  pc + PC_STEP, combinational from pc.
REQ-015 SHALL have fetch_valid  output  1  pc is a live fetch (low during redirect bubble).
REQ-016 SHALL have flush  output  1  one-cycle pulse killing the wrong-path instruction in IF/ID.

Function
REQ-017 Redirect priority SHALL be jr > jump > br_taken; lower-priority requests in the same cycle are ignored.
REQ-018 Branch target SHALL be br_base + (br_offset << 2), modulo 2^32, no overflow indication.
REQ-019 Jump target SHALL be {br_base[31:28], jump_index, 2'b00}; JR target SHALL be jr_target unmodified (no alignment check).
REQ-020 pc_plus4 SHALL equal pc + PC_STEP modulo 2^32; 32'hFFFF_FFFC wraps to 32'h0000_0000.
REQ-021 With no redirect and stall=0, pc SHALL advance to pc_plus4 on each rising edge.
REQ-022 With stall=1 and no redirect, pc SHALL hold its value.
REQ-023 Redirect with stall=0 SHALL load the selected target into pc on the next edge (1-cycle latency) and assert flush for that same cycle the request is seen.
REQ-024 State machine SHALL have states RUN and PEND; reset enters RUN.
REQ-025 RUN: redirect with stall=1 SHALL capture target in a pending register and go to PEND; pc holds.
REQ-026 PEND: while stall=1, pc and captured target SHALL hold; new redirects SHALL overwrite the captured target per REQ-017.
REQ-027 PEND: on first cycle with stall=0, pc SHALL load the captured target (or a new same-cycle redirect, which wins), flush SHALL pulse, state returns to RUN.
REQ-028 fetch_valid SHALL be 0 in PEND and in the cycle flush is asserted, 1 otherwise after reset release.
REQ-029 flush SHALL never assert for more than one consecutive cycle per redirect.

Reset
REQ-030 rst=1 SHALL asynchronously force pc=RESET_PC, state=RUN, pending target=0, flush=0, fetch_valid=0.
REQ-031 First edge after rst deasserts SHALL set fetch_valid=1 with pc=RESET_PC; pc advances on the following edge.
REQ-032 Reset mid-PEND SHALL discard the pending redirect.

Structure
REQ-033 State encoding (RUN/PEND), RESET_PC default and PC_STEP SHALL live in the shared CPU package.
REQ-034 All additions (pc+PC_STEP, branch target) SHALL use one sub-module adder32_cla, a 32-bit adder of chained 4-bit carry-lookahead slices, carry-in 0, no carry-out; two instances.

Verification
REQ-035 Reset release, no stall 4 cycles -> pc = 0x0, 0x4, 0x8, 0xC; fetch_valid=1 from first cycle.
REQ-036 pc=0x100, br_taken, br_base=0x104, br_offset=0xFFFF_FFFE -> next pc=0x0FC, flush one cycle.
REQ-037 jr, jump, br_taken same cycle, jr_target=0x400 -> next pc=0x400, exactly one flush.
REQ-038 stall=1 with jump_index=0x0000010, br_base=0x1000_0008 for 3 cycles -> pc held, PEND; stall drops -> pc=0x1000_0040, flush pulse, fetch_valid 0 during PEND.
REQ-039 pc=0xFFFF_FFFC, no redirect -> next pc=0x0000_0000.
REQ-040 rst asserted mid-PEND, released -> pc=RESET_PC, no flush, pending target lost.
